packed_fill_ctrl: RTL and testbench

//  Sequencer that fills a packed WIDTH-bit output word from a 1-bit source. Two modes:
//  - Broadcast: replicates one bit into every lane in a single step.
//  - Serial: shifts in WIDTH bits under a valid/ready handshake.

---
 rtl/packed_fill_pkg.sv | 13 +
 rtl/packed_fill_shreg.sv | 47 ++++
 rtl/packed_fill_ctrl.sv | 94 +++++++++
 tb/tb_packed_fill_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/packed_fill_pkg.sv
// packed_fill_pkg: shared state encoding and mode constants for the packed fill sequencer
package packed_fill_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam logic MODE_SERIAL = 1'b0;
   localparam logic MODE_BCAST  = 1'b1;

endpackage

// File: rtl/packed_fill_shreg.sv
// packed_fill_shreg: LSB-first indexed shift register with bit counter and assembled-word view
module packed_fill_shreg
   import packed_fill_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_wr,
   input  logic             i_bit,
   output logic             o_last,
   output logic [WIDTH-1:0] o_word
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;

   // Word as it would look with the offered bit written at the current slot
   always_comb begin
      o_word         = shreg_q;
      o_word[cnt_q]  = i_bit;
   end

   // Completion slot: the counter parks here until the final accept
   assign o_last = cnt_q == CW'(WIDTH - 1);

   // Next state: clear wins, then accept; the counter returns to zero after the last bit
   always_comb begin
      shreg_d = i_clr ? '0 : i_wr ? o_word : shreg_q;
      cnt_d   = i_clr ? '0 : i_wr ? (o_last ? '0 : cnt_q + CW'(1)) : cnt_q;
   end

   // State registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/packed_fill_ctrl.sv
// packed_fill_ctrl: fills a packed word by broadcast or serial bit stream and presents it under valid/ready
module packed_fill_ctrl
   import packed_fill_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_mode,
   input  logic             i_abort,
   input  logic             i_bit,
   input  logic             i_bit_valid,
   output logic             o_bit_ready,
   output logic [WIDTH-1:0] o_a,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_busy
);

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic             valid_q, bit_ready_q, busy_q;
   logic             accept, clr, last;
   logic [WIDTH-1:0] word;

   // Abort beats a simultaneous accept; a serial start or an abort wipes partial data
   always_comb begin
      accept = (state_q == FILL) & i_bit_valid & ~i_abort;
      clr    = ((state_q == IDLE) & i_start & (i_mode == MODE_SERIAL)) | ((state_q == FILL) & i_abort);
   end

   packed_fill_shreg #(.WIDTH(WIDTH)) u_shreg (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (clr),
      .i_wr    (accept),
      .i_bit   (i_bit),
      .o_last  (last),
      .o_word  (word)
   );

   // Sequencer with registered handshake outputs; o_a only moves on completion
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         valid_q     <= 1'b0;
         bit_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (i_start) begin
               busy_q <= 1'b1;
               if (i_mode == MODE_BCAST) begin
                  a_q     <= {WIDTH{i_bit}};
                  valid_q <= 1'b1;
                  state_q <= HOLD;
               end else begin
                  bit_ready_q <= 1'b1;
                  state_q     <= FILL;
               end
            end
            FILL: if (i_abort) begin
               bit_ready_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end else if (accept && last) begin
               a_q         <= word;
               bit_ready_q <= 1'b0;
               valid_q     <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: if (i_ready) begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               valid_q     <= 1'b0;
               bit_ready_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign o_a         = a_q;
   assign o_valid     = valid_q;
   assign o_bit_ready = bit_ready_q;
   assign o_busy      = busy_q;

endmodule

// File: tb/tb_packed_fill_ctrl.sv
// tb_packed_fill_ctrl: directed self-checking bench for packed_fill_ctrl
module tb_packed_fill_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start = 1'b0, mode = 1'b0, abort = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, ready = 1'b0;
   logic       bit_ready, valid, busy;
   logic [7:0] a;
   int         n_chk = 0;
   int         n_fail = 0;

   packed_fill_ctrl #(.WIDTH(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_mode      (mode),
      .i_abort     (abort),
      .i_bit       (bit_in),
      .i_bit_valid (bit_valid),
      .o_bit_ready (bit_ready),
      .o_a         (a),
      .o_valid     (valid),
      .i_ready     (ready),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] ea, input logic ev, input logic er, input logic eb);
      chk({tag, ".a"}, a, ea);
      chk({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
      chk({tag, ".bit_ready"}, {7'd0, bit_ready}, {7'd0, er});
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
   endtask

   // Serial fill: start at one edge, then one bit per edge, LSB-first
   task automatic serial_fill(input logic [7:0] w);
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bit_valid = 1'b1; bit_in = w[i];
         tick();
      end
      bit_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] pat;
      // 1. reset
      rst_n = 1'b0;
      repeat (3) tick();
      chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      chk_out("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);

      // 2. broadcast 1 then 0
      start = 1'b1; mode = 1'b1; bit_in = 1'b1;
      tick();
      start = 1'b0;
      chk_out("bcast1", 8'hFF, 1'b1, 1'b0, 1'b1);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk_out("bcast1_done", 8'hFF, 1'b0, 1'b0, 1'b0);
      start = 1'b1; mode = 1'b1; bit_in = 1'b0;
      tick();
      start = 1'b0;
      chk_out("bcast0", 8'h00, 1'b1, 1'b0, 1'b1);
      ready = 1'b1;
      tick();
      ready = 1'b0;

      // 3. serial back-to-back, bits 1,0,1,1,0,0,1,0 -> 4D, valid 9 edges after start
      pat = 8'h4D;
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      chk_out("fill_enter", 8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         bit_valid = 1'b1; bit_in = pat[i];
         tick();
         if (i == 6) chk_out("fill_edge8", 8'h00, 1'b0, 1'b1, 1'b1);
      end
      bit_valid = 1'b0;
      chk_out("fill_done", 8'h4D, 1'b1, 1'b0, 1'b1);
      repeat (5) tick();
      chk_out("hold_stall", 8'h4D, 1'b1, 1'b0, 1'b1);
      // stray broadcast start on the handshake cycle must be ignored
      ready = 1'b1; start = 1'b1; mode = 1'b1; bit_in = 1'b0;
      tick();
      ready = 1'b0; start = 1'b0;
      chk_out("hold_release", 8'h4D, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("idle_after_hs", 8'h4D, 1'b0, 1'b0, 1'b0);

      // 4. serial with gaps and stray starts, eight ones
      start = 1'b1; mode = 1'b0;
      tick();
      mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bit_valid = 1'b1; bit_in = 1'b1; start = 1'b0;
         tick();
         if (i < 7) begin
            chk({"gap_valid", 8'(48 + i)}, {7'd0, valid}, 8'd0);
            bit_valid = 1'b0; bit_in = 1'b0; start = 1'b1;
            tick();
         end
         if (i == 3) chk_out("gap_mid", 8'h4D, 1'b0, 1'b1, 1'b1);
      end
      bit_valid = 1'b0; start = 1'b0;
      chk_out("gap_done", 8'hFF, 1'b1, 1'b0, 1'b1);
      ready = 1'b1;
      tick();
      ready = 1'b0;

      // 5. abort after three accepts, together with a fourth offered bit
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      repeat (3) begin
         bit_valid = 1'b1; bit_in = 1'b1;
         tick();
      end
      abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
      tick();
      abort = 1'b0; bit_valid = 1'b0;
      chk_out("abort", 8'hFF, 1'b0, 1'b0, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_out("abort_idle", 8'hFF, 1'b0, 1'b0, 1'b0);
      serial_fill(8'hAA);
      chk_out("refill", 8'hAA, 1'b1, 1'b0, 1'b1);
      ready = 1'b1;
      tick();
      ready = 1'b0;

      // 6. async reset during FILL (5 bits in) and during HOLD
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      repeat (5) begin
         bit_valid = 1'b1; bit_in = 1'b1;
         tick();
      end
      bit_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_out("arst_fill", 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      start = 1'b1; mode = 1'b1; bit_in = 1'b1;
      tick();
      start = 1'b0;
      chk_out("bcast_after_rst", 8'hFF, 1'b1, 1'b0, 1'b1);
      tick();
      rst_n = 1'b0;
      #1;
      chk_out("arst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      start = 1'b1; mode = 1'b1; bit_in = 1'b1;
      tick();
      start = 1'b0;
      chk_out("bcast_final", 8'hFF, 1'b1, 1'b0, 1'b1);
      serial_fill(8'h00);
      chk_out("no_start_in_hold", 8'hFF, 1'b1, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
